down_count_ctrl: RTL and testbench
==================================

// Module: down_count_ctrl
// PURPOSE
//  Sequencing controller for the 8-bit down counter datapath: loads a start value, runs the countdown,
//  supports pause/resume, abort and auto-reload, and flags terminal count. Sits between control logic
//  and the counter; owns the count register so sequencing is fully synchronous to clk.
// PARAMETERS
//  WIDTH     8   counter width in bits
//  PRESCALE  4   decrement every PRESCALE clk cycles (only with DCNT_PRESCALE_EN; legal >= 1)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      start request, sampled in IDLE only
//  load_val     in   WIDTH  start value, captured when start accepted
//  pause        in   1      high holds count while running
//  abort        in   1      cancel current run, return to IDLE
//  auto_reload  in   1      sampled at terminal count; 1 = reload and continue
//  count        out  WIDTH  current counter value (registered)
//  busy         out  1      high while a countdown is in progress (RUN or PAUSE, count != 0)
//  done         out  1      one-cycle pulse, high in the cycle count becomes 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, count=0, reload_reg=0, busy=0, done=0; overrides everything.
//  - States: IDLE, RUN, PAUSE. Input priority per cycle: rst > abort > pause > terminal/decrement > start.
//  - IDLE: start=1 and load_val=N>0 -> next cycle count=N, reload_reg=N, busy=1, state=RUN.
//    start=1 and load_val=0 -> next cycle done=1, count=0, busy stays 0, stay IDLE.
//  - RUN: each cycle count<=count-1. Transition 1->0: done=1 that cycle, busy=0.
//    auto_reload=0 -> state=IDLE, count holds 0. auto_reload=1 -> next cycle count=reload_reg, busy=1, stay RUN.
//    Latency: start at cycle 0 with N -> count=N at cycle 1, count=0 and done at cycle N+1.
//    Auto-reload period = N+1 cycles (count sequence N..1,0,N..).
//  - pause=1 in RUN -> state=PAUSE, count held (no decrement that cycle); pause=0 -> RUN, decrement resumes
//    the following cycle. pause in same cycle as 1->0 step: pause wins, count holds 1, done deferred.
//  - abort=1 in RUN/PAUSE -> next cycle count=0, busy=0, state=IDLE, done NOT asserted. abort in IDLE ignored.
//  - start while busy ignored (no reload, no restart). pause in IDLE ignored.
//  - count never wraps below 0; done never asserted on two consecutive cycles except load_val=0 back-to-back starts.
// CONFIGURATION
//  DCNT_PRESCALE_EN defined: internal prescaler (ceil(log2(PRESCALE)) bits) generates a decrement
//    tick every PRESCALE cycles; prescaler cleared on start accept, reload, abort, rst; frozen in PAUSE.
//    Latency becomes count=0/done at cycle 1+N*PRESCALE; auto-reload period N*PRESCALE+1 cycles.
//  DCNT_PRESCALE_EN undefined: no prescaler logic; decrement every cycle in RUN; PRESCALE unused.
// TESTING
//  1. rst, load_val=5, start 1 cycle -> count 5,4,3,2,1,0 on cycles 1..6; done only at cycle 6; busy cycles 1..5.
//  2. load_val=6, pause high 3 cycles when count=3 -> count stays 3 for 3 cycles; done at cycle 10 instead of 7.
//  3. load_val=2, auto_reload=1 -> count 2,1,0,2,1,0,...; done every 3rd cycle; busy low only on count=0 cycles.
//  4. load_val=8, abort at count=4 -> next cycle count=0, busy=0, no done; new start with 3 accepted after.
//  5. start with load_val=0 -> done one cycle later, busy never high; start during a run with 9 -> ignored.
//  6. rst asserted mid-run (count=7) -> next edge count=0, busy=0, done=0, IDLE; with DCNT_PRESCALE_EN,
//     PRESCALE=4, load_val=3 -> done at cycle 13.

Source files
------------

// File: rtl/down_count_ctrl.sv
// Sequencing controller for an 8-bit down counter: start/load, countdown, pause, abort, auto-reload.
// Optional prescaled decrement when the DCNT_PRESCALE_EN macro is defined.
module down_count_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic             done_n;
  logic             tick;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("down_count_ctrl: PRESCALE must be >= 1");
  end

`ifdef DCNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] psc, psc_n;

  assign tick = (psc == PW'(PRESCALE - 1));

  // Cleared while idle (covers start accept), on abort and on the reload cycle; frozen while paused.
  always_comb begin
    psc_n = psc;
    if (state == IDLE || abort || (!pause && count == '0)) begin
      psc_n = '0;
    end else if (!pause) begin
      psc_n = tick ? '0 : psc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) psc <= '0;
    else     psc <= psc_n;
  end
`else
  assign tick = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (load_val != '0) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = RUN;
          end else begin
            count_n = '0;
            done_n  = 1'b1;
          end
        end
      end
      RUN, PAUSE: begin
        if (abort) begin
          count_n = '0;
          state_n = IDLE;
        end else if (pause) begin
          state_n = PAUSE;
        end else begin
          state_n = RUN;
          // A zero count while still running only follows an auto-reload terminal count.
          if (count == '0) begin
            count_n = reload_reg;
          end else if (tick) begin
            count_n = count - 1'b1;
            if (count == WIDTH'(1)) begin
              done_n = 1'b1;
              if (!auto_reload) state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      done       <= done_n;
    end
  end

  assign busy = (state != IDLE) && (count != '0);

endmodule

// File: tb/tb_down_count_ctrl.sv
// Self-checking bench for down_count_ctrl: vector table, directed corner sequences,
// and randomized stimulus against a cycle-level reference model.
module tb_down_count_ctrl;

`ifdef DCNT_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, pause, abort, auto_reload;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  down_count_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic [7:0] load_val;
    logic       pause;
    logic       abort;
    logic [7:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic s, input logic [7:0] lv, input logic p, input logic a,
                      input logic ar, input logic r);
    start = s; load_val = lv; pause = p; abort = a; auto_reload = ar; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_out(input string name, input int c, input int b, input int d);
    check({name, ".count"}, 32'(count), 32'(c));
    check({name, ".busy"},  32'(busy),  32'(b));
    check({name, ".done"},  32'(done),  32'(d));
  endtask

  // Reference model: remaining count, reload value, elapsed cycles toward next decrement.
  bit m_run;
  int m_count, m_reload, m_el;
  bit m_done;

  task automatic model_reset();
    m_run = 0; m_count = 0; m_reload = 0; m_el = 0; m_done = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input int lv, input bit p, input bit a,
                            input bit ar);
    m_done = 0;
    if (r) begin
      model_reset();
    end else if (!m_run) begin
      if (s && !a) begin
        if (lv > 0) begin
          m_run = 1; m_count = lv; m_reload = lv; m_el = 0;
        end else begin
          m_count = 0; m_done = 1;
        end
      end
    end else if (a) begin
      m_run = 0; m_count = 0; m_el = 0;
    end else if (!p) begin
      if (m_count == 0) begin
        m_count = m_reload; m_el = 0;
      end else begin
        m_el++;
        if (m_el == P) begin
          m_el = 0;
          m_count--;
          if (m_count == 0) begin
            m_done = 1;
            if (!ar) m_run = 0;
          end
        end
      end
    end
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1, 5, 0, 0, 5, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 4, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 3, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 2, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 4, 0, 0, 4, 1, 0};
    vecs[11] = '{1, 9, 0, 0, 3, 1, 0};
    vecs[12] = '{0, 0, 1, 0, 3, 1, 0};
    vecs[13] = '{0, 0, 0, 0, 2, 1, 0};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 0, 0, 0};
    vecs[16] = '{1, 1, 1, 0, 1, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 1};

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check_out("reset", 0, 0, 0);

`ifndef DCNT_PRESCALE_EN
    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].load_val, vecs[i].pause, vecs[i].abort, 0, 0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Pause for three cycles at count=3 delays done from cycle 7 to cycle 10.
    step(1, 6, 0, 0, 0, 0);
    idle(3);
    check("pause.pre", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 0);
      check_out($sformatf("pause.hold%0d", i), 3, 1, 0);
    end
    idle(2);
    check_out("pause.c9", 1, 1, 0);
    idle(1);
    check_out("pause.c10", 0, 0, 1);

    // Auto-reload with N=2 gives a 3-cycle period.
    step(1, 2, 0, 0, 1, 0);
    check_out("ar.c1", 2, 1, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 1, 0);
      check_out($sformatf("ar.p%0d.one", k), 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      check_out($sformatf("ar.p%0d.zero", k), 0, 0, 1);
      step(0, 0, 0, 0, 1, 0);
      check_out($sformatf("ar.p%0d.reload", k), 2, 1, 0);
    end
    step(0, 0, 0, 1, 0, 0);
    check_out("ar.abort", 0, 0, 0);

    // Abort at count=4, then a fresh start is accepted.
    step(1, 8, 0, 0, 0, 0);
    idle(4);
    check("abort.pre", 32'(count), 32'd4);
    step(0, 0, 0, 1, 0, 0);
    check_out("abort.post", 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    check_out("abort.restart", 3, 1, 0);
    idle(3);
    check_out("abort.restart_done", 0, 0, 1);

    // Reset mid-run at count=7.
    step(1, 9, 0, 0, 0, 0);
    idle(2);
    check("rst.pre", 32'(count), 32'd7);
    step(0, 0, 0, 0, 0, 1);
    check_out("rst.mid", 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    check_out("rst.restart", 3, 1, 0);
    idle(3);
`else
    // Prescaled: N=3, PRESCALE=4 -> done at cycle 13.
    step(1, 3, 0, 0, 0, 0);
    check_out("psc.c1", 3, 1, 0);
    for (int c = 2; c <= 12; c++) begin
      step(0, 0, 0, 0, 0, 0);
      check($sformatf("psc.c%0d.count", c), 32'(count), 32'(3 - (c - 1) / 4));
      check($sformatf("psc.c%0d.done", c), 32'(done), 32'd0);
    end
    idle(1);
    check_out("psc.c13", 0, 0, 1);
`endif

    // Randomized run against the reference model.
    step(0, 0, 0, 0, 0, 1);
    model_reset();
    begin
      bit ar;
      ar = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit r, s, p, a;
        int lv;
        r  = ($urandom_range(0, 99) == 0);
        s  = ($urandom_range(0, 9) < 3);
        p  = ($urandom_range(0, 9) < 2);
        a  = !s && ($urandom_range(0, 19) == 0);
        lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
        if ($urandom_range(0, 15) == 0) ar = !ar;
        step(s, 8'(lv), p, a, ar, r);
        model_step(r, s, lv, p, a, ar);
        check_out($sformatf("rand%0d", cyc), m_count, int'(m_run && m_count != 0), int'(m_done));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
